// File: rtl/param_register_file_pkg.sv
// Shared types and helpers for the parametrised register file.
// Used by every file of the block, including the REGFILE_SHADOW_EN build.
package regfile_pkg;

  localparam int MERGE_W = 256;
  localparam int MERGE_B = MERGE_W / 8;

  typedef enum logic [1:0] {ES, CS, SS, DS} SR_t;

  localparam int SEG_TAP_IDX = int'(CS);

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Byte-lane merge on a wide container; callers zero-extend and truncate to their WIDTH.
  function automatic logic [MERGE_W-1:0] merge(input logic [MERGE_W-1:0] old_v,
                                               input logic [MERGE_W-1:0] new_v,
                                               input logic [MERGE_B-1:0] be);
    logic [MERGE_W-1:0] res;
    res = old_v;
    for (int b = 0; b < MERGE_B; b++)
      if (be[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/param_register_file_if.sv
// Read/write/tap bus of the register file.
// snapshot/restore exist only when REGFILE_SHADOW_EN is defined.
interface param_register_file_if
  import regfile_pkg::*;
#(
  parameter int NUM_REGS     = 4,
  parameter int WIDTH        = 16,
  parameter int NUM_RD_PORTS = 1
);
  localparam int IDX_W = idx_width(NUM_REGS);

  logic [NUM_RD_PORTS-1:0]       rd_en;
  logic [NUM_RD_PORTS*IDX_W-1:0] rd_sel;
  logic [NUM_RD_PORTS*WIDTH-1:0] rd_val;
  logic                          wr_en;
  logic [IDX_W-1:0]              wr_sel;
  logic [WIDTH/8-1:0]            wr_be;
  logic [WIDTH-1:0]              wr_val;
  logic [WIDTH-1:0]              tap_val;
`ifdef REGFILE_SHADOW_EN
  logic                          snapshot;
  logic                          restore;

  modport master (output rd_en, rd_sel, wr_en, wr_sel, wr_be, wr_val, snapshot, restore,
                  input  rd_val, tap_val);
  modport slave  (input  rd_en, rd_sel, wr_en, wr_sel, wr_be, wr_val, snapshot, restore,
                  output rd_val, tap_val);
`else
  modport master (output rd_en, rd_sel, wr_en, wr_sel, wr_be, wr_val,
                  input  rd_val, tap_val);
  modport slave  (input  rd_en, rd_sel, wr_en, wr_sel, wr_be, wr_val,
                  output rd_val, tap_val);
`endif
endinterface

// File: rtl/param_register_file_read_port.sv
// One registered read port: captured index plus output register, kept coherent with writes.
// With REGFILE_SHADOW_EN a restore reloads the output from the shadow bank.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int WIDTH    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rd_en_i,
  input  logic [idx_width(NUM_REGS)-1:0]  rd_sel_i,
  input  logic [WIDTH-1:0]                regs_i [NUM_REGS],
  input  logic                            wr_act_i,
  input  logic [idx_width(NUM_REGS)-1:0]  wr_sel_i,
  input  logic [WIDTH-1:0]                wr_val_i,
`ifdef REGFILE_SHADOW_EN
  input  logic                            restore_i,
  input  logic [WIDTH-1:0]                shadow_i [NUM_REGS],
`endif
  output logic [WIDTH-1:0]                rd_val_o
);
  localparam int IDX_W = idx_width(NUM_REGS);

  logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
  logic [WIDTH-1:0] rd_val_q, rd_val_d;

  // Out-of-range indices match no register and read 0; wr_act_i is never set for them.
  always_comb begin
    cap_idx_d = rd_en_i ? rd_sel_i : cap_idx_q;
    rd_val_d  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cap_idx_d == IDX_W'(i)) begin
`ifdef REGFILE_SHADOW_EN
        rd_val_d = restore_i ? shadow_i[i] : regs_i[i];
`else
        rd_val_d = regs_i[i];
`endif
      end
    end
    if (wr_act_i && wr_sel_i == cap_idx_d) rd_val_d = wr_val_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_idx_q <= '0;
      rd_val_q  <= '0;
    end else begin
      cap_idx_q <= cap_idx_d;
      rd_val_q  <= rd_val_d;
    end
  end

  assign rd_val_o = rd_val_q;

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file: byte-lane writes, forwarding registered read ports, combinational tap.
// Define REGFILE_SHADOW_EN to add the snapshot/restore shadow bank.
module param_register_file
  import regfile_pkg::*;
#(
  parameter int NUM_REGS     = 4,
  parameter int WIDTH        = 16,
  parameter int NUM_RD_PORTS = 1,
  parameter int TAP_IDX      = 1
) (
  input logic                  clk,
  input logic                  reset,
  param_register_file_if.slave bus
);
  localparam int IDX_W  = idx_width(NUM_REGS);
  localparam int IDX_W1 = IDX_W + 1;
  localparam int NB     = WIDTH / 8;
  localparam logic [IDX_W:0] NUM_REGS_C = IDX_W1'(NUM_REGS);

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic [WIDTH-1:0] wr_old, wr_merged;
  logic             wr_act, restore;

  function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] old_v,
                                                  input logic [WIDTH-1:0] new_v,
                                                  input logic [NB-1:0]    be);
    return WIDTH'(merge(MERGE_W'(old_v), MERGE_W'(new_v), MERGE_B'(be)));
  endfunction

`ifdef REGFILE_SHADOW_EN
  logic [WIDTH-1:0] shadow_q [NUM_REGS];
  assign restore = bus.restore;
`else
  assign restore = 1'b0;
`endif

  // A restore owns the cycle, so the write is dropped everywhere, including tap and forwarding.
  assign wr_act = bus.wr_en && ({1'b0, bus.wr_sel} < NUM_REGS_C) && !restore;

  always_comb begin
    wr_old = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (bus.wr_sel == IDX_W'(i)) wr_old = regs_q[i];
  end

  assign wr_merged = lane_merge(wr_old, bus.wr_val, bus.wr_be);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
`ifdef REGFILE_SHADOW_EN
      regs_d[i] = restore ? shadow_q[i] : regs_q[i];
`else
      regs_d[i] = regs_q[i];
`endif
      if (wr_act && bus.wr_sel == IDX_W'(i)) regs_d[i] = wr_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

`ifdef REGFILE_SHADOW_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
    end else if (bus.snapshot && !restore) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= regs_d[i];
    end
  end
`endif

  assign bus.tap_val = (wr_act && bus.wr_sel == IDX_W'(TAP_IDX)) ? wr_merged : regs_q[TAP_IDX];

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    regfile_read_port #(
      .NUM_REGS (NUM_REGS),
      .WIDTH    (WIDTH)
    ) u_port (
      .clk       (clk),
      .reset     (reset),
      .rd_en_i   (bus.rd_en[p]),
      .rd_sel_i  (bus.rd_sel[p*IDX_W +: IDX_W]),
      .regs_i    (regs_q),
      .wr_act_i  (wr_act),
      .wr_sel_i  (bus.wr_sel),
      .wr_val_i  (wr_merged),
`ifdef REGFILE_SHADOW_EN
      .restore_i (restore),
      .shadow_i  (shadow_q),
`endif
      .rd_val_o  (bus.rd_val[p*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench: segment-bank instance (4x16, 1 port) and a 5x16, 2-port instance.
// Shadow checks are compiled in only with REGFILE_SHADOW_EN.
module tb_param_register_file;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  param_register_file_if #(.NUM_REGS(4), .WIDTH(16), .NUM_RD_PORTS(1)) bus_a ();
  param_register_file_if #(.NUM_REGS(5), .WIDTH(16), .NUM_RD_PORTS(2)) bus_b ();

  param_register_file #(.NUM_REGS(4), .WIDTH(16), .NUM_RD_PORTS(1), .TAP_IDX(SEG_TAP_IDX))
    dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
  param_register_file #(.NUM_REGS(5), .WIDTH(16), .NUM_RD_PORTS(2), .TAP_IDX(1))
    dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  typedef struct {
    logic        rst;
    logic [1:0]  rd_en;
    logic [2:0]  sel0, sel1;
    logic        wr_en;
    logic [2:0]  wsel;
    logic [1:0]  be;
    logic [15:0] wv;
    logic [15:0] e_tap, e_rd0, e_rd1;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] rd_en, input logic [2:0] sel0,
                              input logic [2:0] sel1, input logic wr_en, input logic [2:0] wsel,
                              input logic [1:0] be, input logic [15:0] wv, input logic [15:0] e_tap,
                              input logic [15:0] e_rd0, input logic [15:0] e_rd1);
    vec_t v;
    v.rst = rst; v.rd_en = rd_en; v.sel0 = sel0; v.sel1 = sel1; v.wr_en = wr_en;
    v.wsel = wsel; v.be = be; v.wv = wv; v.e_tap = e_tap; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic a_drive(input logic en, input logic [1:0] sel, input logic we,
                         input logic [1:0] ws, input logic [1:0] be, input logic [15:0] wv);
    @(negedge clk);
    bus_a.rd_en  = en;
    bus_a.rd_sel = sel;
    bus_a.wr_en  = we;
    bus_a.wr_sel = ws;
    bus_a.wr_be  = be;
    bus_a.wr_val = wv;
    #1;
  endtask

  task automatic a_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.rd_en = '0; bus_a.rd_sel = '0; bus_a.wr_en = 1'b0;
    bus_a.wr_sel = '0; bus_a.wr_be = '0; bus_a.wr_val = '0;
    bus_b.rd_en = '0; bus_b.rd_sel = '0; bus_b.wr_en = 1'b0;
    bus_b.wr_sel = '0; bus_b.wr_be = '0; bus_b.wr_val = '0;
`ifdef REGFILE_SHADOW_EN
    bus_a.snapshot = 1'b0; bus_a.restore = 1'b0;
    bus_b.snapshot = 1'b0; bus_b.restore = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    // ---------------- segment bank (4x16, 1 port, tap = CS) ----------------
    #1;
    chk("a_reset_rd", bus_a.rd_val, 16'h0000);
    chk("a_reset_tap", bus_a.tap_val, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      a_drive(1'b1, i[1:0], 1'b0, 2'd0, 2'b00, 16'h0000);
      a_edge();
      chk($sformatf("a_read0_r%0d", i), bus_a.rd_val, 16'h0000);
    end
    a_drive(1'b1, 2'd2, 1'b1, 2'd2, 2'b11, 16'hBEEF);
    a_edge();
    chk("a_fwd_beef", bus_a.rd_val, 16'hBEEF);
    a_drive(1'b0, 2'd0, 1'b1, 2'd3, 2'b11, 16'h1234);
    a_edge();
    chk("a_hold_other_wr", bus_a.rd_val, 16'hBEEF);
    a_drive(1'b1, 2'd3, 1'b0, 2'd0, 2'b00, 16'h0000);
    a_edge();
    chk("a_read_r3", bus_a.rd_val, 16'h1234);
    a_drive(1'b0, 2'd0, 1'b1, 2'd3, 2'b10, 16'hAB00);
    a_edge();
    chk("a_held_merge", bus_a.rd_val, 16'hAB34);
    a_drive(1'b0, 2'd0, 1'b0, 2'd0, 2'b00, 16'h0000);
    a_edge();
    chk("a_held_stays", bus_a.rd_val, 16'hAB34);
    a_drive(1'b0, 2'd0, 1'b1, 2'd1, 2'b11, 16'h0F0F);
    chk("a_tap_wr_cycle", bus_a.tap_val, 16'h0F0F);
    a_edge();
    a_drive(1'b0, 2'd0, 1'b1, 2'd1, 2'b01, 16'h0055);
    chk("a_tap_lane_merge", bus_a.tap_val, 16'h0F55);
    a_edge();
    a_drive(1'b0, 2'd0, 1'b0, 2'd0, 2'b00, 16'h0000);
    chk("a_tap_after", bus_a.tap_val, 16'h0F55);
    a_edge();
    chk("a_held_after_tap", bus_a.rd_val, 16'hAB34);

`ifdef REGFILE_SHADOW_EN
    a_drive(1'b1, 2'd0, 1'b1, 2'd0, 2'b11, 16'h1111);
    a_edge();
    chk("s_r0_1111", bus_a.rd_val, 16'h1111);
    a_drive(1'b0, 2'd0, 1'b0, 2'd0, 2'b00, 16'h0000);
    bus_a.snapshot = 1'b1;
    a_edge();
    a_drive(1'b0, 2'd0, 1'b1, 2'd0, 2'b11, 16'h2222);
    bus_a.snapshot = 1'b0;
    a_edge();
    chk("s_r0_2222", bus_a.rd_val, 16'h2222);
    a_drive(1'b0, 2'd0, 1'b1, 2'd0, 2'b11, 16'h3333);
    bus_a.restore = 1'b1;
    a_edge();
    chk("s_restore_rd", bus_a.rd_val, 16'h1111);
    a_drive(1'b1, 2'd0, 1'b0, 2'd0, 2'b00, 16'h0000);
    bus_a.restore = 1'b0;
    a_edge();
    chk("s_reread_r0", bus_a.rd_val, 16'h1111);
    a_drive(1'b0, 2'd0, 1'b1, 2'd1, 2'b11, 16'h4444);
    bus_a.snapshot = 1'b1;
    a_edge();
    a_drive(1'b0, 2'd0, 1'b1, 2'd1, 2'b11, 16'h5555);
    bus_a.snapshot = 1'b0;
    a_edge();
    chk("s_tap_5555", bus_a.tap_val, 16'h5555);
    a_drive(1'b0, 2'd0, 1'b0, 2'd0, 2'b00, 16'h0000);
    bus_a.snapshot = 1'b1; bus_a.restore = 1'b1;
    a_edge();
    chk("s_tap_restored", bus_a.tap_val, 16'h4444);
    a_drive(1'b0, 2'd0, 1'b1, 2'd1, 2'b11, 16'h6666);
    bus_a.snapshot = 1'b0; bus_a.restore = 1'b0;
    a_edge();
    a_drive(1'b0, 2'd0, 1'b0, 2'd0, 2'b00, 16'h0000);
    bus_a.restore = 1'b1;
    a_edge();
    chk("s_shadow_kept", bus_a.tap_val, 16'h4444);
    @(negedge clk);
    bus_a.restore = 1'b0;
`endif

    // ---------------- 5x16, 2 ports, tap = 1 ----------------
    //             rst rd_en sel0 sel1 we wsel be      wv        tap       rd0       rd1
    vq.push_back(mk(0, 2'b11, 1, 1, 1, 1, 2'b11, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F));
    vq.push_back(mk(0, 2'b01, 2, 4, 1, 2, 2'b11, 16'hBEEF, 16'h0F0F, 16'hBEEF, 16'h0F0F));
    vq.push_back(mk(0, 2'b10, 0, 3, 1, 3, 2'b11, 16'h1234, 16'h0F0F, 16'hBEEF, 16'h1234));
    vq.push_back(mk(0, 2'b00, 0, 0, 1, 3, 2'b10, 16'hAB00, 16'h0F0F, 16'hBEEF, 16'hAB34));
    vq.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 16'h0000, 16'h0F0F, 16'hBEEF, 16'hAB34));
    vq.push_back(mk(0, 2'b00, 0, 0, 1, 1, 2'b01, 16'h5566, 16'h0F66, 16'hBEEF, 16'hAB34));
    vq.push_back(mk(0, 2'b00, 0, 0, 1, 2, 2'b00, 16'hFFFF, 16'h0F66, 16'hBEEF, 16'hAB34));
    vq.push_back(mk(0, 2'b11, 6, 5, 1, 6, 2'b11, 16'hFFFF, 16'h0F66, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 2'b00, 0, 0, 1, 5, 2'b11, 16'hFFFF, 16'h0F66, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 2'b11, 4, 0, 0, 0, 2'b00, 16'h0000, 16'h0F66, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 2'b11, 2, 3, 0, 0, 2'b00, 16'h0000, 16'h0F66, 16'hBEEF, 16'hAB34));
    vq.push_back(mk(0, 2'b11, 1, 4, 0, 0, 2'b00, 16'h0000, 16'h0F66, 16'h0F66, 16'h0000));
    vq.push_back(mk(0, 2'b11, 4, 4, 1, 4, 2'b11, 16'hC3C3, 16'h0F66, 16'hC3C3, 16'hC3C3));
    vq.push_back(mk(1, 2'b00, 0, 0, 1, 1, 2'b11, 16'h7777, 16'h7777, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 2'b00, 0, 0, 1, 0, 2'b11, 16'h00A5, 16'h0000, 16'h00A5, 16'h00A5));
    vq.push_back(mk(0, 2'b11, 1, 2, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000));

    foreach (vq[i]) begin
      @(negedge clk);
      rst_b        = vq[i].rst;
      bus_b.rd_en  = vq[i].rd_en;
      bus_b.rd_sel = {vq[i].sel1, vq[i].sel0};
      bus_b.wr_en  = vq[i].wr_en;
      bus_b.wr_sel = vq[i].wsel;
      bus_b.wr_be  = vq[i].be;
      bus_b.wr_val = vq[i].wv;
      #1;
      chk($sformatf("b_v%0d_tap", i), bus_b.tap_val, vq[i].e_tap);
      @(posedge clk);
      #1;
      chk($sformatf("b_v%0d_rd0", i), bus_b.rd_val[15:0], vq[i].e_rd0);
      chk($sformatf("b_v%0d_rd1", i), bus_b.rd_val[31:16], vq[i].e_rd1);
    end
    @(negedge clk);
    rst_b = 1'b0; bus_b.rd_en = '0; bus_b.wr_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
